tug_of_war_field: RTL and testbench
===================================

Name: tug_of_war_field

Overview:
- Game-core stage directly downstream of the per-player edge detectors.
- Consumes one-cycle press pulses from the left and right players and moves a single lit LED across an NUM_LEDS-wide playfield.
- Detects a round win when the light is pushed off either end, and keeps saturating per-player scores.
- Sequences round-end hold and game-over, and drives the LED bar and score displays of the board top level.

Parameters:
NUM_LEDS, 9, playfield width; must be odd and >= 3. CENTER = (NUM_LEDS-1)/2.
HOLD_CYCLES, 4, cycles the blank/winner display is held after a round win; must be >= 1. The board top overrides it with a larger value.
MAX_SCORE, 7, score that ends the game; must be >= 1 and <= 2**SCORE_W-1.
SCORE_W, 3, score output width.

Ports:
clk  input  1  system clock, all state updates on posedge.
reset  input  1  synchronous, active-low reset: sampled on posedge clk, asserted when 0.
l_pulse  input  1  single-cycle press pulse from the left player's edge detector.
r_pulse  input  1  single-cycle press pulse from the right player's edge detector.
leds  output  NUM_LEDS  playfield; one-hot during play. Bit NUM_LEDS-1 is the leftmost LED.
winner  output  2  last round winner: 2'b00 none, 2'b01 left, 2'b10 right.
l_score  output  SCORE_W  left player's round wins.
r_score  output  SCORE_W  right player's round wins.
game_over  output  1  high once either score reaches MAX_SCORE.

Behaviour:
- All outputs are registered; an input sampled at posedge k is reflected in the outputs just after posedge k.
- Reset (reset==0 at a posedge) takes priority over everything, including mid-round, mid-hold and game-over. Reset values:
  - state=PLAY, pos=CENTER, leds=1<<CENTER (9'b000010000 for the default).
  - l_score=0, r_score=0, winner=00, game_over=0, hold counter=0.
- FSM states: PLAY, ROUND_END, GAME_OVER.
- PLAY, action taken on each posedge by pulse combination:
  - l_pulse and r_pulse both high: no movement; they cancel.
  - l_pulse only, pos<NUM_LEDS-1: pos+1.
  - l_pulse only, pos==NUM_LEDS-1: left wins the round.
  - r_pulse only, pos>0: pos-1.
  - r_pulse only, pos==0: right wins the round.
  - Neither pulse: hold.
- On a round win, all of the following happen on the same edge:
  - Winner's score increments, saturating at MAX_SCORE.
  - winner is set to the winning side and leds go to 0.
  - If the new score == MAX_SCORE, next state is GAME_OVER; otherwise next state is ROUND_END with the hold counter loaded with HOLD_CYCLES-1.
- ROUND_END:
  - leds stay 0 and winner is held.
  - All pulses are ignored.
  - The counter decrements each cycle. On the edge where the counter is 0, the FSM moves to PLAY with pos=CENTER and winner=00.
  - Net effect: leds read 0 for exactly HOLD_CYCLES cycles.
- GAME_OVER:
  - leds=0, winner and scores frozen, game_over=1.
  - All pulses are ignored; the state is left only via reset.
- leds has exactly one bit set in PLAY and is zero in the other two states. pos never leaves 0..NUM_LEDS-1.
- The pos register width is $clog2(NUM_LEDS). The hold counter width is $clog2(HOLD_CYCLES) with a minimum of 1 bit.
- Pulses held high for multiple cycles are not filtered here: each high cycle counts as one move. The upstream edge detector guarantees single-cycle pulses.

Decomposition:
- Package tug_of_war_pkg holds:
  - state_t enum {PLAY, ROUND_END, GAME_OVER}.
  - winner_t enum {WIN_NONE=2'b00, WIN_LEFT=2'b01, WIN_RIGHT=2'b10}.
  - Shared constants used by the board top and the bench.
- Sub-module score_counter:
  - SCORE_W-bit saturating up-counter with inputs clk, reset (same active-low synchronous reset), inc; parameter MAX.
  - Outputs count and at_max.
  - Instantiated twice, once per player.

Test Plan:
- Reset: drive reset=0 for one edge with l_pulse=1 -> leds=9'b000010000, scores 0, winner 00, game_over 0; no movement is taken during reset.
- Movement: 2 separate l_pulse cycles from reset -> leds=9'b001000000; then 3 r_pulse -> leds=9'b000001000; a cycle with both pulses high -> leds unchanged.
- Left round win: 4 l_pulse cycles (pos=8), then 1 more -> leds=0, winner=01, l_score=1 on that edge. Pulses during the next 4 cycles have no effect. Then leds=9'b000010000 and winner=00.
- Right win with reset mid-hold: 5 r_pulse cycles -> r_score=1, ROUND_END. Assert reset on the 2nd hold cycle -> all outputs return to reset values on the next edge.
- Game over (MAX_SCORE=2): right wins twice -> r_score=2, game_over=1, winner=10, leds=0. Further l/r pulses for 10 cycles change nothing. Reset -> PLAY, scores 0.
- Width/param (NUM_LEDS=3, HOLD_CYCLES=1): from reset, l,l -> left wins, leds=0 for exactly 1 cycle, then 3'b010.

Source files
------------

// File: rtl/tug_of_war_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tug_of_war_pkg
// Brief    : Shared types and board-level defaults for the tug-of-war game core.
// Revision : 1.0 - initial release
// ============================================================================
package tug_of_war_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        ROUND_END = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_t;

    localparam int DEF_NUM_LEDS    = 9;
    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_MAX_SCORE   = 7;
    localparam int DEF_SCORE_W     = 3;

endpackage
`default_nettype wire

// File: rtl/tug_of_war_if.sv
`default_nettype none
// ============================================================================
// Module   : tug_of_war_if
// Brief    : Player pulses in, playfield and score displays out.
// Revision : 1.0 - initial release
// ============================================================================
interface tug_of_war_if #(
    parameter int NUM_LEDS = 9,
    parameter int SCORE_W  = 3
);
    logic                l_pulse;
    logic                r_pulse;
    logic [NUM_LEDS-1:0] leds;
    logic [1:0]          winner;
    logic [SCORE_W-1:0]  l_score;
    logic [SCORE_W-1:0]  r_score;
    logic                game_over;

    modport master (
        output l_pulse, r_pulse,
        input  leds, winner, l_score, r_score, game_over
    );

    modport slave (
        input  l_pulse, r_pulse,
        output leds, winner, l_score, r_score, game_over
    );
endinterface
`default_nettype wire

// File: rtl/score_counter.sv
`default_nettype none
// ============================================================================
// Module   : score_counter
// Brief    : Saturating per-player round-win counter.
// Revision : 1.0 - initial release
// ============================================================================
module score_counter #(
    parameter int SCORE_W = 3,
    parameter int MAX     = 7
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               inc,
    output logic [SCORE_W-1:0]      count,
    output logic                    at_max
);
    localparam logic [SCORE_W-1:0] c_max = SCORE_W'(MAX);

    logic [SCORE_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count  = r_count;
    assign at_max = (r_count == c_max);
endmodule
`default_nettype wire

// File: rtl/tug_of_war_field.sv
`default_nettype none
// ============================================================================
// Module   : tug_of_war_field
// Brief    : Moves the lit LED on player pulses, scores round wins, sequences
//            round-end hold and game-over.
// Revision : 1.0 - initial release
// ============================================================================
module tug_of_war_field
    import tug_of_war_pkg::*;
#(
    parameter int NUM_LEDS    = DEF_NUM_LEDS,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int MAX_SCORE   = DEF_MAX_SCORE,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  wire logic     clk,
    input  wire logic     reset,
    tug_of_war_if.slave   bus
);
    localparam int POS_W  = $clog2(NUM_LEDS);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [POS_W-1:0]   c_center    = POS_W'((NUM_LEDS - 1) / 2);
    localparam logic [POS_W-1:0]   c_last      = POS_W'(NUM_LEDS - 1);
    localparam logic [HOLD_W-1:0]  c_hold_load = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_final_pre = SCORE_W'(MAX_SCORE - 1);
    localparam logic [NUM_LEDS-1:0] c_one      = NUM_LEDS'(1);

    state_t              r_state,  w_state_next;
    logic [POS_W-1:0]    r_pos,    w_pos_next;
    logic [HOLD_W-1:0]   r_hold,   w_hold_next;
    logic [NUM_LEDS-1:0] r_leds,   w_leds_next;
    winner_t             r_winner, w_winner_next;
    logic                w_l_inc, w_r_inc;
    logic [SCORE_W-1:0]  w_l_score, w_r_score;
    logic                w_l_at_max, w_r_at_max;

    score_counter #(.SCORE_W(SCORE_W), .MAX(MAX_SCORE)) u_l_score (
        .clk(clk), .reset(reset), .inc(w_l_inc), .count(w_l_score), .at_max(w_l_at_max)
    );

    score_counter #(.SCORE_W(SCORE_W), .MAX(MAX_SCORE)) u_r_score (
        .clk(clk), .reset(reset), .inc(w_r_inc), .count(w_r_score), .at_max(w_r_at_max)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= PLAY;
            r_pos    <= c_center;
            r_hold   <= '0;
            r_leds   <= c_one << c_center;
            r_winner <= WIN_NONE;
        end else begin
            r_state  <= w_state_next;
            r_pos    <= w_pos_next;
            r_hold   <= w_hold_next;
            r_leds   <= w_leds_next;
            r_winner <= w_winner_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pos_next    = r_pos;
        w_hold_next   = r_hold;
        w_leds_next   = r_leds;
        w_winner_next = r_winner;
        w_l_inc       = 1'b0;
        w_r_inc       = 1'b0;

        case (r_state)
            PLAY: begin
                // Simultaneous presses cancel, so only exclusive pulses act.
                if (bus.l_pulse && !bus.r_pulse) begin
                    if (r_pos == c_last) begin
                        w_l_inc       = 1'b1;
                        w_winner_next = WIN_LEFT;
                        w_leds_next   = '0;
                        if (w_l_score == c_final_pre) begin
                            w_state_next = GAME_OVER;
                        end else begin
                            w_state_next = ROUND_END;
                            w_hold_next  = c_hold_load;
                        end
                    end else begin
                        w_pos_next  = r_pos + 1'b1;
                        w_leds_next = c_one << w_pos_next;
                    end
                end else if (bus.r_pulse && !bus.l_pulse) begin
                    if (r_pos == '0) begin
                        w_r_inc       = 1'b1;
                        w_winner_next = WIN_RIGHT;
                        w_leds_next   = '0;
                        if (w_r_score == c_final_pre) begin
                            w_state_next = GAME_OVER;
                        end else begin
                            w_state_next = ROUND_END;
                            w_hold_next  = c_hold_load;
                        end
                    end else begin
                        w_pos_next  = r_pos - 1'b1;
                        w_leds_next = c_one << w_pos_next;
                    end
                end
            end
            ROUND_END: begin
                if (r_hold == '0) begin
                    w_state_next  = PLAY;
                    w_pos_next    = c_center;
                    w_leds_next   = c_one << c_center;
                    w_winner_next = WIN_NONE;
                end else begin
                    w_hold_next = r_hold - 1'b1;
                end
            end
            GAME_OVER: begin
                w_leds_next = '0;
            end
            default: begin
                w_state_next  = PLAY;
                w_pos_next    = c_center;
                w_leds_next   = c_one << c_center;
                w_winner_next = WIN_NONE;
            end
        endcase
    end

    assign bus.leds      = r_leds;
    assign bus.winner    = r_winner;
    assign bus.l_score   = w_l_score;
    assign bus.r_score   = w_r_score;
    assign bus.game_over = w_l_at_max | w_r_at_max;
endmodule
`default_nettype wire

// File: tb/tb_tug_of_war_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_tug_of_war_field
// Brief    : Directed bench for tug_of_war_field: default, MAX_SCORE=2 and
//            3-LED / 1-cycle-hold configurations side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tug_of_war_field;
    import tug_of_war_pkg::*;

    logic clk;
    logic reset;
    integer checks;
    integer failures;

    tug_of_war_if #(.NUM_LEDS(DEF_NUM_LEDS), .SCORE_W(DEF_SCORE_W)) bus_a ();
    tug_of_war_if #(.NUM_LEDS(DEF_NUM_LEDS), .SCORE_W(DEF_SCORE_W)) bus_g ();
    tug_of_war_if #(.NUM_LEDS(3),            .SCORE_W(DEF_SCORE_W)) bus_s ();

    tug_of_war_field #(.NUM_LEDS(DEF_NUM_LEDS), .HOLD_CYCLES(DEF_HOLD_CYCLES),
                       .MAX_SCORE(DEF_MAX_SCORE), .SCORE_W(DEF_SCORE_W))
        u_dut (.clk(clk), .reset(reset), .bus(bus_a));

    tug_of_war_field #(.NUM_LEDS(DEF_NUM_LEDS), .HOLD_CYCLES(DEF_HOLD_CYCLES),
                       .MAX_SCORE(2), .SCORE_W(DEF_SCORE_W))
        u_go (.clk(clk), .reset(reset), .bus(bus_g));

    tug_of_war_field #(.NUM_LEDS(3), .HOLD_CYCLES(1),
                       .MAX_SCORE(DEF_MAX_SCORE), .SCORE_W(DEF_SCORE_W))
        u_small (.clk(clk), .reset(reset), .bus(bus_s));

    always #5 clk = ~clk;

    task automatic tick_a(input logic l, input logic r);
        bus_a.l_pulse = l; bus_a.r_pulse = r;
        @(posedge clk); #1;
        bus_a.l_pulse = 1'b0; bus_a.r_pulse = 1'b0;
    endtask

    task automatic tick_g(input logic l, input logic r);
        bus_g.l_pulse = l; bus_g.r_pulse = r;
        @(posedge clk); #1;
        bus_g.l_pulse = 1'b0; bus_g.r_pulse = 1'b0;
    endtask

    task automatic tick_s(input logic l, input logic r);
        bus_s.l_pulse = l; bus_s.r_pulse = r;
        @(posedge clk); #1;
        bus_s.l_pulse = 1'b0; bus_s.r_pulse = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        tick_a(1'b1, 1'b0);
        tick_a(1'b1, 1'b0);
        reset = 1'b0;
        tick_a(1'b1, 1'b0);
        reset = 1'b1;
        checks++;
        if (bus_a.leds !== 9'b000010000) begin
            failures++; $display("FAIL reset_leds got=%b exp=%b", bus_a.leds, 9'b000010000);
        end
        checks++;
        if ({bus_a.l_score, bus_a.r_score, bus_a.winner, bus_a.game_over} !== 9'b0) begin
            failures++;
            $display("FAIL reset_state got l=%0d r=%0d w=%b go=%b exp all zero",
                     bus_a.l_score, bus_a.r_score, bus_a.winner, bus_a.game_over);
        end
    endtask

    task automatic test_movement();
        do_reset();
        tick_a(1'b1, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b000100000) begin
            failures++; $display("FAIL move_l1 got=%b exp=%b", bus_a.leds, 9'b000100000);
        end
        tick_a(1'b1, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b001000000) begin
            failures++; $display("FAIL move_l2 got=%b exp=%b", bus_a.leds, 9'b001000000);
        end
        repeat (3) tick_a(1'b0, 1'b1);
        checks++;
        if (bus_a.leds !== 9'b000001000) begin
            failures++; $display("FAIL move_r3 got=%b exp=%b", bus_a.leds, 9'b000001000);
        end
        tick_a(1'b1, 1'b1);
        checks++;
        if (bus_a.leds !== 9'b000001000) begin
            failures++; $display("FAIL move_both got=%b exp=%b", bus_a.leds, 9'b000001000);
        end
        tick_a(1'b0, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b000001000) begin
            failures++; $display("FAIL move_idle got=%b exp=%b", bus_a.leds, 9'b000001000);
        end
    endtask

    task automatic test_left_win();
        do_reset();
        repeat (4) tick_a(1'b1, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b100000000) begin
            failures++; $display("FAIL lwin_edge got=%b exp=%b", bus_a.leds, 9'b100000000);
        end
        tick_a(1'b1, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b0 || bus_a.winner !== 2'b01 || bus_a.l_score !== 3'd1
            || bus_a.r_score !== 3'd0 || bus_a.game_over !== 1'b0) begin
            failures++;
            $display("FAIL lwin_hit got leds=%b w=%b l=%0d r=%0d go=%b exp leds=0 w=01 l=1 r=0 go=0",
                     bus_a.leds, bus_a.winner, bus_a.l_score, bus_a.r_score, bus_a.game_over);
        end
        for (int i = 0; i < 3; i++) begin
            tick_a(i[0], ~i[0]);
            checks++;
            if (bus_a.leds !== 9'b0 || bus_a.winner !== 2'b01) begin
                failures++;
                $display("FAIL lwin_hold%0d got leds=%b w=%b exp leds=0 w=01", i, bus_a.leds, bus_a.winner);
            end
        end
        tick_a(1'b1, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b000010000 || bus_a.winner !== 2'b00 || bus_a.l_score !== 3'd1) begin
            failures++;
            $display("FAIL lwin_resume got leds=%b w=%b l=%0d exp leds=000010000 w=00 l=1",
                     bus_a.leds, bus_a.winner, bus_a.l_score);
        end
    endtask

    task automatic test_right_win_reset();
        do_reset();
        repeat (5) tick_a(1'b0, 1'b1);
        checks++;
        if (bus_a.leds !== 9'b0 || bus_a.winner !== 2'b10 || bus_a.r_score !== 3'd1) begin
            failures++;
            $display("FAIL rwin_hit got leds=%b w=%b r=%0d exp leds=0 w=10 r=1",
                     bus_a.leds, bus_a.winner, bus_a.r_score);
        end
        tick_a(1'b0, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b0) begin
            failures++; $display("FAIL rwin_hold1 got=%b exp=0", bus_a.leds);
        end
        reset = 1'b0;
        tick_a(1'b0, 1'b1);
        reset = 1'b1;
        checks++;
        if (bus_a.leds !== 9'b000010000 || bus_a.winner !== 2'b00 || bus_a.r_score !== 3'd0
            || bus_a.l_score !== 3'd0 || bus_a.game_over !== 1'b0) begin
            failures++;
            $display("FAIL rwin_midreset got leds=%b w=%b l=%0d r=%0d go=%b exp reset values",
                     bus_a.leds, bus_a.winner, bus_a.l_score, bus_a.r_score, bus_a.game_over);
        end
        tick_a(1'b1, 1'b0);
        checks++;
        if (bus_a.leds !== 9'b000100000) begin
            failures++; $display("FAIL rwin_playable got=%b exp=%b", bus_a.leds, 9'b000100000);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        repeat (5) tick_g(1'b0, 1'b1);
        checks++;
        if (bus_g.r_score !== 3'd1 || bus_g.game_over !== 1'b0) begin
            failures++;
            $display("FAIL go_first got r=%0d go=%b exp r=1 go=0", bus_g.r_score, bus_g.game_over);
        end
        repeat (4) tick_g(1'b0, 1'b0);
        checks++;
        if (bus_g.leds !== 9'b000010000) begin
            failures++; $display("FAIL go_resume got=%b exp=%b", bus_g.leds, 9'b000010000);
        end
        repeat (5) tick_g(1'b0, 1'b1);
        checks++;
        if (bus_g.r_score !== 3'd2 || bus_g.game_over !== 1'b1 || bus_g.winner !== 2'b10
            || bus_g.leds !== 9'b0) begin
            failures++;
            $display("FAIL go_end got r=%0d go=%b w=%b leds=%b exp r=2 go=1 w=10 leds=0",
                     bus_g.r_score, bus_g.game_over, bus_g.winner, bus_g.leds);
        end
        for (int i = 0; i < 10; i++) begin
            tick_g(i[0], i[1]);
            checks++;
            if (bus_g.r_score !== 3'd2 || bus_g.l_score !== 3'd0 || bus_g.game_over !== 1'b1
                || bus_g.winner !== 2'b10 || bus_g.leds !== 9'b0) begin
                failures++;
                $display("FAIL go_frozen%0d got l=%0d r=%0d go=%b w=%b leds=%b exp l=0 r=2 go=1 w=10 leds=0",
                         i, bus_g.l_score, bus_g.r_score, bus_g.game_over, bus_g.winner, bus_g.leds);
            end
        end
        do_reset();
        checks++;
        if (bus_g.r_score !== 3'd0 || bus_g.game_over !== 1'b0 || bus_g.leds !== 9'b000010000) begin
            failures++;
            $display("FAIL go_reset got r=%0d go=%b leds=%b exp r=0 go=0 leds=000010000",
                     bus_g.r_score, bus_g.game_over, bus_g.leds);
        end
    endtask

    task automatic test_small_field();
        do_reset();
        checks++;
        if (bus_s.leds !== 3'b010) begin
            failures++; $display("FAIL small_reset got=%b exp=010", bus_s.leds);
        end
        tick_s(1'b1, 1'b0);
        checks++;
        if (bus_s.leds !== 3'b100) begin
            failures++; $display("FAIL small_l1 got=%b exp=100", bus_s.leds);
        end
        tick_s(1'b1, 1'b0);
        checks++;
        if (bus_s.leds !== 3'b000 || bus_s.winner !== 2'b01 || bus_s.l_score !== 3'd1) begin
            failures++;
            $display("FAIL small_win got leds=%b w=%b l=%0d exp leds=000 w=01 l=1",
                     bus_s.leds, bus_s.winner, bus_s.l_score);
        end
        tick_s(1'b0, 1'b1);
        checks++;
        if (bus_s.leds !== 3'b010 || bus_s.winner !== 2'b00) begin
            failures++;
            $display("FAIL small_resume got leds=%b w=%b exp leds=010 w=00", bus_s.leds, bus_s.winner);
        end
        tick_s(1'b0, 1'b1);
        checks++;
        if (bus_s.leds !== 3'b001) begin
            failures++; $display("FAIL small_r1 got=%b exp=001", bus_s.leds);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        checks = 0;
        failures = 0;
        bus_a.l_pulse = 1'b0; bus_a.r_pulse = 1'b0;
        bus_g.l_pulse = 1'b0; bus_g.r_pulse = 1'b0;
        bus_s.l_pulse = 1'b0; bus_s.r_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        test_reset();
        test_movement();
        test_left_win();
        test_right_win_reset();
        test_game_over();
        test_small_field();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
